// File: rtl/ps2_host_tx_if.sv
// ---------------------------------------------------------------------------
// ps2_host_tx_if
// Signal bundle between the PS/2 host transmitter and its surroundings: the
// byte-level request handshake, the raw open-drain pin levels and pull-low
// enables, and the status/completion outputs.
//   TX_DATA/TX_VALID/TX_READY  byte request handshake
//   PS2_CLK_IN/PS2_DATA_IN     raw pin levels (asynchronous)
//   PS2_CLK_OE/PS2_DATA_OE     1 = pull the corresponding line low
//   BUSY                       transmitter owns the bus
//   TX_DONE/TX_ERR/ERR_CODE    completion pulses and error reason
// Modports: slave = the transmitter, master = user logic plus pin environment.
// ---------------------------------------------------------------------------
interface ps2_host_tx_if;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;
  logic       PS2_CLK_IN;
  logic       PS2_DATA_IN;
  logic       PS2_CLK_OE;
  logic       PS2_DATA_OE;
  logic       BUSY;
  logic       TX_DONE;
  logic       TX_ERR;
  logic [1:0] ERR_CODE;

  modport slave (
    input  TX_DATA, TX_VALID, PS2_CLK_IN, PS2_DATA_IN,
    output TX_READY, PS2_CLK_OE, PS2_DATA_OE, BUSY, TX_DONE, TX_ERR, ERR_CODE
  );

  modport master (
    output TX_DATA, TX_VALID, PS2_CLK_IN, PS2_DATA_IN,
    input  TX_READY, PS2_CLK_OE, PS2_DATA_OE, BUSY, TX_DONE, TX_ERR, ERR_CODE
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard
// over the shared open-drain clock/data pair: inhibits the clock, issues a
// request-to-send, then shifts data LSB first, odd parity and stop on each
// device clock fall, and finally checks the device ACK.
// Ports:
//   CLK   system clock
//   RST   synchronous active-high reset
//   bus   ps2_host_tx_if.slave (handshake, pins, status; see interface)
// Parameters:
//   INHIBIT_CYCLES  cycles PS2_CLK is held low before request-to-send
//   RTS_CYCLES      cycles DATA and CLK are both held low
//   TIMEOUT_CYCLES  max cycles from CLK release to end of ACK
//   FILTER_LEN      consecutive equal samples needed to change a filtered line
// ---------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic         CLK,
  input  logic         RST,
  ps2_host_tx_if.slave bus
);

  localparam int PH_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FL_W   = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE
  } state_t;

  state_t state, state_n;

  // Index 0 is PS2_CLK, index 1 is PS2_DATA throughout the conditioning path.
  logic [1:0]           sync_p0;
  logic [1:0]           sync_p1;
  logic [1:0]           filt;
  logic [1:0][FL_W-1:0] filt_cnt;
  logic                 clk_filt_d;
  logic                 fall;

  logic [9:0]      shift;
  logic [3:0]      idx;
  logic            data_oe_r;
  logic [PH_W-1:0] ph_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            tx_done_r;
  logic            tx_err_r;
  logic [1:0]      err_code_r;

  logic       accept;
  logic       bit_step;
  logic       timeout;
  logic       done_n;
  logic       err_n;
  logic [1:0] err_code_n;

  // Stage p0/p1: two-flop synchronizer for both raw pins.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_p0 <= 2'b11;
      sync_p1 <= 2'b11;
    end else begin
      sync_p0 <= {bus.PS2_DATA_IN, bus.PS2_CLK_IN};
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: glitch filter. A line only changes after FILTER_LEN consecutive
  // synced samples disagree with the current filtered value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      filt       <= 2'b11;
      filt_cnt   <= '0;
      clk_filt_d <= 1'b1;
    end else begin
      clk_filt_d <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == filt[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == FL_W'(FILTER_LEN - 1)) begin
          filt[i]     <= sync_p1[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign fall    = clk_filt_d & ~filt[0];
  assign timeout = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  // Timeout is tested before the fall so it wins when both coincide.
  always_comb begin
    state_n    = state;
    accept     = 1'b0;
    bit_step   = 1'b0;
    done_n     = 1'b0;
    err_n      = 1'b0;
    err_code_n = err_code_r;
    unique case (state)
      IDLE: begin
        if (bus.TX_VALID) begin
          accept  = 1'b1;
          state_n = INHIBIT;
        end
      end
      INHIBIT: begin
        if (ph_cnt == PH_W'(INHIBIT_CYCLES - 1)) state_n = RTS;
      end
      RTS: begin
        if (ph_cnt == PH_W'(RTS_CYCLES - 1)) state_n = SEND;
      end
      SEND: begin
        if (timeout) begin
          err_n      = 1'b1;
          err_code_n = 2'd1;
          state_n    = IDLE;
        end else if (fall) begin
          bit_step = 1'b1;
          if (idx == 4'd9) state_n = ACK;
        end
      end
      ACK: begin
        if (timeout) begin
          err_n      = 1'b1;
          err_code_n = 2'd1;
          state_n    = IDLE;
        end else if (fall) begin
          if (!filt[1]) begin
            state_n = WAIT_IDLE;
          end else begin
            err_n      = 1'b1;
            err_code_n = 2'd2;
            state_n    = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (timeout) begin
          err_n      = 1'b1;
          err_code_n = 2'd1;
          state_n    = IDLE;
        end else if (filt[0] && filt[1]) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ph_cnt     <= '0;
      to_cnt     <= '0;
      idx        <= '0;
      data_oe_r  <= 1'b0;
      tx_done_r  <= 1'b0;
      tx_err_r   <= 1'b0;
      err_code_r <= 2'd0;
    end else begin
      tx_done_r  <= done_n;
      tx_err_r   <= err_n;
      err_code_r <= err_code_n;

      if (state_n != state)
        ph_cnt <= '0;
      else if (state == INHIBIT || state == RTS)
        ph_cnt <= ph_cnt + 1'b1;

      // The timeout window opens at CLK release, i.e. on entry to SEND.
      if (state == RTS && state_n == SEND)
        to_cnt <= '0;
      else if (state == SEND || state == ACK || state == WAIT_IDLE)
        to_cnt <= to_cnt + 1'b1;

      if (accept)
        idx <= '0;
      else if (bit_step)
        idx <= idx + 1'b1;

      // Start bit stays asserted until the first fall; the stop bit (1)
      // naturally releases DATA on the tenth fall.
      if (state == RTS && state_n == SEND)
        data_oe_r <= 1'b1;
      else if (bit_step)
        data_oe_r <= ~shift[idx];
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) shift <= {1'b1, ~^bus.TX_DATA, bus.TX_DATA};
  end

  assign bus.TX_READY    = (state == IDLE);
  assign bus.BUSY        = (state != IDLE);
  assign bus.PS2_CLK_OE  = (state == INHIBIT) || (state == RTS);
  assign bus.PS2_DATA_OE = (state == RTS) || ((state == SEND) && data_oe_r);
  assign bus.TX_DONE     = tx_done_r;
  assign bus.TX_ERR      = tx_err_r;
  assign bus.ERR_CODE    = err_code_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Drives command bytes into ps2_host_tx while a PS/2 device model clocks the
// frame out, decodes it and ACKs (or misbehaves). Expected outcomes are queued
// when each byte is issued; a monitor pops and compares them whenever the
// transmitter pulses TX_DONE or TX_ERR.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

  localparam int INH  = 50;
  localparam int RTSC = 16;
  localparam int TO   = 3000;
  localparam int FL   = 8;
  localparam int HALF = 40;

  localparam int M_OK     = 0;
  localparam int M_NOACK  = 1;
  localparam int M_NOCLK  = 2;
  localparam int M_RST    = 3;
  localparam int M_GLITCH = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       is_err;
    logic [1:0] code;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         rel_cyc = 0;
  int         err_cyc = 0;
  int         busy_seen;
  int         mode_r;
  logic [7:0] cap_byte = '0;
  logic [7:0] r;
  logic [1:0] model_code = 2'd0;
  exp_t       exp_q[$];
  exp_t       mon_e;

  ps2_host_tx_if bus();

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .RTS_CYCLES    (RTSC),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN    (FL)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Open-drain wired-AND of the device model and the host pull-downs.
  assign bus.PS2_CLK_IN  = dev_clk & ~bus.PS2_CLK_OE;
  assign bus.PS2_DATA_IN = dev_data & ~bus.PS2_DATA_OE;

  task automatic check(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: every completion pulse must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (!RST && (bus.TX_DONE || bus.TX_ERR)) begin
      if (bus.TX_ERR) err_cyc = cyc;
      check("pulse_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("done_xor_err", int'(bus.TX_DONE ^ bus.TX_ERR), 1);
        check("outcome_is_err", int'(bus.TX_ERR), int'(mon_e.is_err));
        check("err_code", int'(bus.ERR_CODE), int'(mon_e.code));
        check("oe_released", int'({bus.PS2_CLK_OE, bus.PS2_DATA_OE}), 0);
        check("ready_at_end", int'(bus.TX_READY), 1);
        if (!mon_e.is_err) check("frame_byte", int'(cap_byte), int'(mon_e.data));
      end
    end
  end

  // Issue a byte and queue the outcome the protocol rules predict for it.
  task automatic send(input logic [7:0] d, input int mode);
    exp_t e;
    int   k;
    k = 0;
    while (!bus.TX_READY && k < 10000) begin
      @(negedge CLK);
      k++;
    end
    check("ready_wait", int'(bus.TX_READY), 1);
    bus.TX_DATA  = d;
    bus.TX_VALID = 1'b1;
    if (mode != M_RST) begin
      e.data   = d;
      e.is_err = 1'b0;
      if (mode == M_NOACK) begin
        model_code = 2'd2;
        e.is_err   = 1'b1;
      end else if (mode == M_NOCLK) begin
        model_code = 2'd1;
        e.is_err   = 1'b1;
      end
      e.code = model_code;
      exp_q.push_back(e);
    end
    @(negedge CLK);
    bus.TX_VALID = 1'b0;
  endtask

  // Device model: measures the inhibit, then clocks 11 pulses, sampling host
  // data on each rise (bits 0-7, parity, stop) and ACKing before the 11th fall.
  task automatic device(input logic [7:0] d, input int mode);
    logic [9:0] bits;
    logic       exp_par;
    int         k;
    int         len;
    exp_par = ($countones(d) % 2 == 0);
    k = 0;
    while (!bus.PS2_CLK_OE && k < 200) begin
      @(negedge CLK);
      k++;
    end
    check("inhibit_start", int'(bus.PS2_CLK_OE), 1);
    len = 0;
    while (bus.PS2_CLK_OE && len < 20000) begin
      @(negedge CLK);
      len++;
    end
    check("clk_low_cycles", len, INH + RTSC);
    check("start_bit_oe", int'(bus.PS2_DATA_OE), 1);
    rel_cyc = cyc;
    if (mode == M_NOCLK) return;
    bits = '0;
    for (int i = 1; i <= 11; i++) begin
      repeat (HALF / 2) @(negedge CLK);
      if (mode == M_RST && i == 5) begin
        RST = 1'b1;
        @(negedge CLK);
        check("rst_clk_oe", int'(bus.PS2_CLK_OE), 0);
        check("rst_data_oe", int'(bus.PS2_DATA_OE), 0);
        check("rst_busy", int'(bus.BUSY), 0);
        RST = 1'b0;
        model_code = 2'd0;
        return;
      end
      if (mode == M_GLITCH && i == 5) dev_clk = 1'b0;
      repeat (4) @(negedge CLK);
      dev_clk = 1'b1;
      if (i == 11 && mode != M_NOACK) dev_data = 1'b0;
      repeat (HALF / 2 - 4) @(negedge CLK);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge CLK);
      dev_clk = 1'b1;
      if (i <= 10) bits[i-1] = bus.PS2_DATA_IN;
      if (i == 10) cap_byte = bits[7:0];
      if (i == 11) dev_data = 1'b1;
    end
    check("frame_data", int'(bits[7:0]), int'(d));
    check("frame_parity", int'(bits[8]), int'(exp_par));
    check("frame_stop", int'(bits[9]), 1);
  endtask

  task automatic wait_outcome();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 6000) begin
      @(negedge CLK);
      k++;
    end
    check("outcome_seen", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge CLK);
  endtask

  task automatic run(input logic [7:0] d, input int mode);
    send(d, mode);
    device(d, mode);
    wait_outcome();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.TX_DATA  = 8'h00;
    bus.TX_VALID = 1'b0;
    RST = 1'b1;
    repeat (5) @(negedge CLK);
    check("rst_ready", int'(bus.TX_READY), 1);
    check("rst_busy0", int'(bus.BUSY), 0);
    check("rst_done", int'(bus.TX_DONE), 0);
    check("rst_err", int'(bus.TX_ERR), 0);
    check("rst_code", int'(bus.ERR_CODE), 0);
    check("rst_oes", int'({bus.PS2_CLK_OE, bus.PS2_DATA_OE}), 0);
    RST = 1'b0;
    @(negedge CLK);

    run(8'hED, M_OK);
    run(8'h01, M_OK);
    run(8'h00, M_OK);

    r = 8'($urandom);
    run(r, M_NOACK);
    r = 8'($urandom);
    run(r, M_OK);

    r = 8'($urandom);
    run(r, M_NOCLK);
    check("timeout_latency", err_cyc - rel_cyc, TO);

    send(8'h3C, M_RST);
    device(8'h3C, M_RST);
    repeat (60) @(negedge CLK);
    check("ready_after_rst", int'(bus.TX_READY), 1);
    check("code_after_rst", int'(bus.ERR_CODE), int'(model_code));
    run(8'hFF, M_OK);

    r = 8'($urandom);
    fork
      run(r, M_GLITCH);
      begin
        repeat (300) @(negedge CLK);
        bus.TX_DATA  = 8'h55;
        bus.TX_VALID = 1'b1;
        @(negedge CLK);
        bus.TX_VALID = 1'b0;
      end
    join
    busy_seen = 0;
    repeat (INH + RTSC + 20) begin
      @(negedge CLK);
      if (bus.BUSY) busy_seen = 1;
    end
    check("busy_valid_ignored", busy_seen, 0);

    for (int t = 0; t < 4; t++) begin
      r = 8'($urandom);
      mode_r = ($urandom_range(0, 3) == 0) ? M_NOACK : M_OK;
      run(r, mode_r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
